// File: rtl/ddc_mix_fs4_pkg.sv
// ddc_pkg: shared types and constants for the fs/4 complex mixer.
//   mix_mode_e : mode encodings; 2'b11 decodes as bypass, like 2'b10
//   coef_e     : per-output coefficient select (0, +1, -1)
//   *_LUT      : phase-to-coefficient tables; phase p occupies bits [2p +: 2]
//   coef_at    : reads one table entry for a given phase
package ddc_pkg;

  typedef enum logic [1:0] {
    MIX_DOWN = 2'b00,
    MIX_UP   = 2'b01,
    MIX_BYP  = 2'b10
  } mix_mode_e;

  typedef enum logic [1:0] {
    COEF_ZERO = 2'b00,
    COEF_POS  = 2'b01,
    COEF_NEG  = 2'b10
  } coef_e;

  // cos = {1, 0, -1, 0}
  localparam logic [7:0] COS_LUT    = 8'b00_10_00_01;
  // sin (down) = {0, -1, 0, 1}
  localparam logic [7:0] SIN_DN_LUT = 8'b01_00_10_00;
  // sin (up) = {0, 1, 0, -1}
  localparam logic [7:0] SIN_UP_LUT = 8'b10_00_01_00;

  function automatic coef_e coef_at(input logic [7:0] lut, input logic [1:0] ph);
    return coef_e'(lut[{ph, 1'b0} +: 2]);
  endfunction

endpackage

// File: rtl/ddc_mix_fs4_if.sv
// ddc_mix_fs4_if: sample-stream bundle for the fs/4 mixer.
//   in_valid/in_data/sync_in/mode_cfg : source -> mixer
//   out_valid/out_i/out_q/out_phase   : mixer -> decimator
// Modports: master = upstream source, slave = the mixer.
interface ddc_mix_fs4_if #(
  parameter int unsigned DW  = 16,
  parameter int unsigned NCH = 1
) ();

  logic              in_valid;
  logic [NCH*DW-1:0] in_data;
  logic              sync_in;
  logic [1:0]        mode_cfg;
  logic              out_valid;
  logic [NCH*DW-1:0] out_i;
  logic [NCH*DW-1:0] out_q;
  logic [1:0]        out_phase;

  modport master (
    output in_valid, in_data, sync_in, mode_cfg,
    input  out_valid, out_i, out_q, out_phase
  );

  modport slave (
    input  in_valid, in_data, sync_in, mode_cfg,
    output out_valid, out_i, out_q, out_phase
  );

endinterface

// File: rtl/ddc_mix_fs4_lane.sv
// ddc_mix_lane: stage-2 datapath for one lane of the fs/4 mixer.
//   clk, rst   : clock, async active-high reset
//   en         : stage-1 sample is valid; outputs update only then
//   x          : stage-1 sample
//   ci, cq     : coefficient selects for I and Q
//   i_out/q_out: registered I/Q results (hold when en=0)
//   sat        : (MIX_SAT_EN only) combinational pulse, this sample saturates
// Optional feature macro: MIX_SAT_EN (clamp -(-2^(DW-1)) to 2^(DW-1)-1).
module ddc_mix_lane
  import ddc_pkg::*;
#(
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [DW-1:0] x,
  input  coef_e         ci,
  input  coef_e         cq,
  output logic [DW-1:0] i_out,
  output logic [DW-1:0] q_out
`ifdef MIX_SAT_EN
  ,
  output logic          sat
`endif
);

  logic [DW-1:0] neg;
  logic [DW-1:0] i_d, q_d;

`ifdef MIX_SAT_EN
  logic is_min;
  assign is_min = (x == {1'b1, {(DW-1){1'b0}}});

  always_comb begin
    neg = -x;
    if (is_min) neg = {1'b0, {(DW-1){1'b1}}};
  end

  // Only a selected negation of the most-negative value saturates.
  assign sat = en & is_min & ((ci == COEF_NEG) | (cq == COEF_NEG));
`else
  // Plain wrap: -(-2^(DW-1)) stays -2^(DW-1).
  assign neg = -x;
`endif

  function automatic logic [DW-1:0] pick(input coef_e c, input logic [DW-1:0] pos,
                                         input logic [DW-1:0] ng);
    logic [DW-1:0] r;
    unique case (c)
      COEF_POS: r = pos;
      COEF_NEG: r = ng;
      default:  r = '0;
    endcase
    return r;
  endfunction

  always_comb begin
    i_d = pick(ci, x, neg);
    q_d = pick(cq, x, neg);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_out <= '0;
      q_out <= '0;
    end else if (en) begin
      i_out <= i_d;
      q_out <= q_d;
    end
  end

endmodule

// File: rtl/ddc_mix_fs4.sv
// ddc_mix_fs4: parametrised fs/4 complex mixer, NCH lanes, 2-cycle latency.
//   clk, rst  : sample clock, async active-high reset
//   bus       : ddc_mix_fs4_if.slave (input stream, mode/sync, I/Q outputs)
//   sat_flag  : (MIX_SAT_EN only) sticky, set when any negation saturated
// Optional feature macro: MIX_SAT_EN.
// Owns the phase counter, the mode register and the valid pipeline; the
// per-lane negate/zero/saturate lives in ddc_mix_lane.
module ddc_mix_fs4
  import ddc_pkg::*;
#(
  parameter int unsigned DW  = 16,
  parameter int unsigned NCH = 1
) (
  input  logic          clk,
  input  logic          rst,
  ddc_mix_fs4_if.slave  bus
`ifdef MIX_SAT_EN
  ,
  output logic          sat_flag
`endif
);

  logic [1:0] ph_q, ph_d;
  logic [1:0] mode_q, mode_d;
  logic [1:0] ph_use, mode_use;
  coef_e      ci_d, cq_d;

  // Stage 1
  logic              valid1_q;
  logic [NCH*DW-1:0] x1_q;
  coef_e             ci1_q, cq1_q;
  logic [1:0]        ph1_q;

  // Stage 2
  logic              out_valid_q;
  logic [1:0]        out_phase_q;
  logic [NCH*DW-1:0] out_i_w, out_q_w;

  always_comb begin
    ph_use   = bus.sync_in ? 2'd0 : ph_q;
    // A phase-0 sample already runs in the mode it captures.
    mode_use = (ph_use == 2'd0) ? bus.mode_cfg : mode_q;
    ph_d     = ph_q;
    mode_d   = mode_q;
    if (bus.in_valid) begin
      ph_d = ph_use + 2'd1;
      if (ph_use == 2'd0) mode_d = bus.mode_cfg;
    end else if (bus.sync_in) begin
      ph_d = 2'd0;
    end
  end

  always_comb begin
    ci_d = COEF_POS;
    cq_d = COEF_ZERO;
    if (!mode_use[1]) begin
      ci_d = coef_at(COS_LUT, ph_use);
      cq_d = coef_at((mode_use == MIX_UP) ? SIN_UP_LUT : SIN_DN_LUT, ph_use);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph_q   <= 2'd0;
      mode_q <= MIX_DOWN;
    end else begin
      ph_q   <= ph_d;
      mode_q <= mode_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid1_q <= 1'b0;
      x1_q     <= '0;
      ci1_q    <= COEF_ZERO;
      cq1_q    <= COEF_ZERO;
      ph1_q    <= 2'd0;
    end else begin
      valid1_q <= bus.in_valid;
      if (bus.in_valid) begin
        x1_q  <= bus.in_data;
        ci1_q <= ci_d;
        cq1_q <= cq_d;
        ph1_q <= ph_use;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_phase_q <= 2'd0;
    end else begin
      out_valid_q <= valid1_q;
      if (valid1_q) out_phase_q <= ph1_q;
    end
  end

`ifdef MIX_SAT_EN
  logic [NCH-1:0] sat_pulse;
  logic           sat_flag_q;
`endif

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    ddc_mix_lane #(
      .DW(DW)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .en    (valid1_q),
      .x     (x1_q[k*DW +: DW]),
      .ci    (ci1_q),
      .cq    (cq1_q),
      .i_out (out_i_w[k*DW +: DW]),
      .q_out (out_q_w[k*DW +: DW])
`ifdef MIX_SAT_EN
      ,
      .sat   (sat_pulse[k])
`endif
    );
  end

`ifdef MIX_SAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sat_flag_q <= 1'b0;
    else     sat_flag_q <= sat_flag_q | (|sat_pulse);
  end
  assign sat_flag = sat_flag_q;
`endif

  assign bus.out_valid = out_valid_q;
  assign bus.out_phase = out_phase_q;
  assign bus.out_i     = out_i_w;
  assign bus.out_q     = out_q_w;

endmodule

// File: tb/tb_ddc_mix_fs4.sv
// Scoreboard bench for ddc_mix_fs4 (DW=16, NCH=4). The driver pushes the
// expected response of each accepted sample, computed from the mixing rules
// with integer arithmetic; a negedge monitor pops and compares.
module tb_ddc_mix_fs4;

  localparam int unsigned DW  = 16;
  localparam int unsigned NCH = 4;
  localparam int unsigned W   = NCH * DW;
  localparam int MAXV = (1 << (DW - 1)) - 1;
  localparam int MINV = -(1 << (DW - 1));

  typedef struct {
    logic [W-1:0] i;
    logic [W-1:0] q;
    logic [1:0]   ph;
    logic         sat;
    int           stamp;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  exp_t sb[$];
  int   m_ph = 0;
  int   m_mode = 0;
  logic m_sat = 1'b0;
  logic [W-1:0] last_i = '0;
  logic [W-1:0] last_q = '0;
  logic [1:0]   last_ph = '0;

  int cos_t[4]  = '{1, 0, -1, 0};
  int sin_dn[4] = '{0, -1, 0, 1};
  int sin_up[4] = '{0, 1, 0, -1};

  ddc_mix_fs4_if #(.DW(DW), .NCH(NCH)) bus ();

`ifdef MIX_SAT_EN
  logic sat_flag;
`endif

  ddc_mix_fs4 #(
    .DW (DW),
    .NCH(NCH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus)
`ifdef MIX_SAT_EN
    ,
    .sat_flag(sat_flag)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%h exp=%h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] scale(input int x, input int c, output logic hit);
    int r;
    r   = x * c;
    hit = 1'b0;
`ifdef MIX_SAT_EN
    if (r > MAXV) begin
      r   = MAXV;
      hit = 1'b1;
    end
`endif
    return r[DW-1:0];
  endfunction

  task automatic model(input logic v, input logic s, input logic [1:0] m,
                       input logic [W-1:0] d);
    exp_t e;
    int   p, xi, ci, cq;
    logic h1, h2;
    if (v) begin
      p = s ? 0 : m_ph;
      if (p == 0) m_mode = int'(m);
      for (int k = 0; k < NCH; k++) begin
        xi = int'($signed(d[k*DW +: DW]));
        if (m_mode >= 2) begin
          ci = 1;
          cq = 0;
        end else begin
          ci = cos_t[p];
          cq = (m_mode == 1) ? sin_up[p] : sin_dn[p];
        end
        e.i[k*DW +: DW] = scale(xi, ci, h1);
        e.q[k*DW +: DW] = scale(xi, cq, h2);
        if (h1 || h2) m_sat = 1'b1;
      end
      e.ph    = 2'(p);
      e.sat   = m_sat;
      e.stamp = cyc + 2;
      sb.push_back(e);
      m_ph = (p + 1) % 4;
    end else if (s) begin
      m_ph = 0;
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic [1:0] m,
                       input logic [W-1:0] d);
    @(posedge clk);
    #1;
    bus.in_valid = v;
    bus.sync_in  = s;
    bus.mode_cfg = m;
    bus.in_data  = d;
    model(v, s, m, d);
  endtask

  function automatic logic [W-1:0] rep(input int x);
    logic [DW-1:0] l;
    l = x[DW-1:0];
    return {NCH{l}};
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, W'(bus.out_valid), '0);
    chk({tag, "_i"}, bus.out_i, '0);
    chk({tag, "_q"}, bus.out_q, '0);
    chk({tag, "_phase"}, W'(bus.out_phase), '0);
`ifdef MIX_SAT_EN
    chk({tag, "_sat"}, W'(sat_flag), '0);
`endif
  endtask

  // Asserted between edges; outputs must clear without waiting for a clock.
  task automatic async_reset();
    @(posedge clk);
    #3;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.sync_in  = 1'b0;
    sb.delete();
    m_ph   = 0;
    m_mode = 0;
    m_sat  = 1'b0;
    last_i = '0;
    last_q = '0;
    last_ph = '0;
    #1;
    check_zero("rst_mid");
    @(posedge clk);
    #3;
    rst = 1'b0;
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!rst) begin
      exp_t e;
      logic exp_v;
      exp_v = (sb.size() > 0) && (sb[0].stamp <= cyc);
      chk("out_valid", W'(bus.out_valid), W'(exp_v));
      if (bus.out_valid && sb.size() > 0) begin
        e = sb.pop_front();
        chk("latency", W'(cyc), W'(e.stamp));
        chk("out_i", bus.out_i, e.i);
        chk("out_q", bus.out_q, e.q);
        chk("out_phase", W'(bus.out_phase), W'(e.ph));
`ifdef MIX_SAT_EN
        chk("sat_flag", W'(sat_flag), W'(e.sat));
`endif
        last_i  = e.i;
        last_q  = e.q;
        last_ph = e.ph;
      end else if (!bus.out_valid && exp_v) begin
        void'(sb.pop_front());
      end else if (!bus.out_valid) begin
        chk("hold_i", bus.out_i, last_i);
        chk("hold_q", bus.out_q, last_q);
        chk("hold_phase", W'(bus.out_phase), W'(last_ph));
      end
    end
  end

  initial begin
    logic [W-1:0] d;
    logic [1:0] pat;
    bus.in_valid = 1'b0;
    bus.sync_in  = 1'b0;
    bus.mode_cfg = 2'b00;
    bus.in_data  = '0;
    #1 rst = 1'b1;
    #2;
    check_zero("rst_init");
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    // Down-mode sweep, x = 100
    repeat (8) drive(1'b1, 1'b0, 2'b00, rep(100));

    // Gapped valid in up mode, x = 7
    pat = 2'b00;
    for (int j = 0; j < 6; j++) begin
      drive((j == 1 || j == 4) ? 1'b0 : 1'b1, 1'b0, 2'b01, rep(7));
    end

    // Bypass requested at phase 2 takes effect at next phase 0
    drive(1'b1, 1'b0, 2'b00, rep(11));
    drive(1'b1, 1'b0, 2'b00, rep(12));
    drive(1'b1, 1'b0, 2'b10, rep(13));
    drive(1'b1, 1'b0, 2'b10, rep(14));
    repeat (4) drive(1'b1, 1'b0, 2'b10, rep(-15));

    // Sync with valid at phase 2
    drive(1'b1, 1'b0, 2'b00, rep(3));
    drive(1'b1, 1'b0, 2'b00, rep(4));
    drive(1'b1, 1'b1, 2'b00, rep(5));
    drive(1'b1, 1'b0, 2'b00, rep(6));

    // Sync without valid, then a sample at phase 0
    drive(1'b0, 1'b1, 2'b00, rep(0));
    drive(1'b1, 1'b0, 2'b00, rep(9));

    // Most-negative value negated at phase 2 in down mode
    drive(1'b1, 1'b0, 2'b00, rep(1));
    drive(1'b1, 1'b0, 2'b00, rep(MINV));
    drive(1'b1, 1'b0, 2'b00, rep(MINV));
    drive(1'b1, 1'b0, 2'b00, rep(2));
    drive(1'b0, 1'b0, 2'b00, rep(0));

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < NCH; k++) begin
        d[k*DW +: DW] = ($urandom_range(0, 7) == 0) ? DW'(MINV) : DW'($urandom);
      end
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
            2'($urandom_range(0, 3)), d);
    end

    // Reset mid-stream with distinct lanes
    drive(1'b1, 1'b0, 2'b01, {16'h1234, 16'h8000, 16'h7fff, 16'h0042});
    drive(1'b1, 1'b0, 2'b01, {16'h1111, 16'h2222, 16'h3333, 16'h4444});
    async_reset();
    drive(1'b1, 1'b0, 2'b00, {16'h0004, 16'h0003, 16'h0002, 16'h0001});
    drive(1'b1, 1'b0, 2'b00, {16'hfffc, 16'h0030, 16'h0200, 16'h1000});
    drive(1'b0, 1'b0, 2'b00, '0);

    repeat (5) @(posedge clk);
    #2;
    chk("drain", W'(sb.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
